// File: rtl/mips_cpu_bus_tb_stall_bridge.sv
// -----------------------------------------------------------------------------
// mips_cpu_bus_tb_stall_bridge
//
// Bridge between the CPU's Avalon-style master port and the byte-addressed
// bench memory. Every CPU transfer is held under waitrequest for a number of
// stall cycles. It is then issued to memory as a single-cycle read or write
// strobe, and it completes to the CPU in the following cycle. The bridge also
// counts completed transfers and keeps a sticky flag for protocol violations.
//
// Optional feature (macro STALL_RANDOM_EN):
//   defined   - stall length = lfsr[7:0] & STALL_MASK, sampled when a request
//               is accepted. The LFSR is a 16-bit Fibonacci LFSR
//               (taps 16,14,13,11, seed 16'hACE1) that steps every clock.
//   undefined - stall length = STALL_CYCLES for every transfer.
//
// Parameters:
//   STALL_CYCLES  fixed stall cycles before each memory issue (0..255)
//   STALL_MASK    mask applied to the LFSR for the random stall length
//   MEM_AW        memory address width (mem_addr = cpu_address[MEM_AW-1:0])
//
// Ports:
//   clk, reset_n        clock; asynchronous active-low reset
//   cpu_address/read/write/byteenable/writedata   CPU request
//   cpu_waitrequest     stall to the CPU (combinational)
//   cpu_readdata        read data to the CPU, valid when waitrequest is low
//   mem_read/mem_write  one-cycle strobes to memory
//   mem_addr/byteenable/writedata   latched transfer attributes
//   mem_readdata        memory data, returned one cycle after mem_read
//   protocol_err        sticky protocol-violation flag
//   txn_count           completed transfers (wraps)
// -----------------------------------------------------------------------------
module mips_cpu_bus_tb_stall_bridge #(
    parameter int unsigned STALL_CYCLES = 3,
    parameter logic [7:0]  STALL_MASK   = 8'h07,
    parameter int unsigned MEM_AW       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [3:0]        cpu_byteenable,
    input  logic [31:0]       cpu_writedata,
    output logic              cpu_waitrequest,
    output logic [31:0]       cpu_readdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              protocol_err,
    output logic [31:0]       txn_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [7:0] STALL_FIXED = 8'(STALL_CYCLES);

    state_t      state_q;
    state_t      state_d;
    logic        op_write_q;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q;
    logic [7:0]  stall_len;
    logic        req;
    logic        one_req;
    logic        accept;
    logic        busy;
    logic        mismatch;
    logic        violation;

    // Upper address bits are deliberately ignored, and only one of the two
    // stall-length sources is used in any given build.
    logic unused_cfg;
    assign unused_cfg = ^{cpu_address[31:MEM_AW], STALL_MASK, STALL_FIXED};

`ifdef STALL_RANDOM_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall_len = lfsr_q[7:0] & STALL_MASK;
`else
    assign stall_len = STALL_FIXED;
`endif

    assign req     = cpu_read | cpu_write;
    assign one_req = cpu_read ^ cpu_write;
    assign accept  = (state_q == IDLE) && one_req;
    assign busy    = (state_q == WAIT) || (state_q == ISSUE);

    // While a transfer is held, the CPU must keep the same operation and
    // attributes. Dropping the request also shows up here as an op mismatch.
    assign mismatch = (cpu_read  != !op_write_q)
                   || (cpu_write !=  op_write_q)
                   || (cpu_address[MEM_AW-1:0] != mem_addr)
                   || (cpu_byteenable != mem_byteenable)
                   || (cpu_writedata  != mem_writedata);

    assign violation = ((state_q == IDLE) && cpu_read && cpu_write)
                    || (busy && mismatch);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (one_req) begin
                    state_d = (stall_len != 8'd0) ? WAIT : ISSUE;
                end
            end
            WAIT: begin
                // Counter <= 1 is treated as the last stall cycle.
                if (cnt_q <= 8'd1) begin
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_read        = (state_q == ISSUE) && !op_write_q;
        mem_write       = (state_q == ISSUE) &&  op_write_q;
        cpu_waitrequest = req && (state_q != RESP);
        cpu_readdata    = (state_q == RESP) ? mem_readdata : rdata_q;
    end

    // Transfer attributes, stall counter, read-data hold, statistics
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr       <= '0;
            mem_byteenable <= '0;
            mem_writedata  <= '0;
            op_write_q     <= 1'b0;
            cnt_q          <= '0;
            rdata_q        <= '0;
            protocol_err   <= 1'b0;
            txn_count      <= '0;
        end else begin
            if (accept) begin
                mem_addr       <= cpu_address[MEM_AW-1:0];
                mem_byteenable <= cpu_byteenable;
                mem_writedata  <= cpu_writedata;
                op_write_q     <= cpu_write;
                cnt_q          <= stall_len;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 8'd1;
            end

            if (state_q == RESP) begin
                rdata_q   <= mem_readdata;
                txn_count <= txn_count + 32'd1;
            end

            if (violation) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_tb_stall_bridge.sv
// -----------------------------------------------------------------------------
// Testbench for mips_cpu_bus_tb_stall_bridge.
// Instance 1 uses STALL_CYCLES=3, instance 0 uses STALL_CYCLES=0. Each has its
// own small byte-addressed memory model with registered read data.
// -----------------------------------------------------------------------------
module tb_mips_cpu_bus_tb_stall_bridge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [31:0] c_addr [2];
    logic        c_rd   [2];
    logic        c_wr   [2];
    logic [3:0]  c_be   [2];
    logic [31:0] c_wd   [2];
    logic        wreq   [2];
    logic [31:0] rdata  [2];
    logic        m_rd   [2];
    logic        m_wr   [2];
    logic [15:0] m_addr [2];
    logic [3:0]  m_be   [2];
    logic [31:0] m_wd   [2];
    logic [31:0] m_rdata[2];
    logic        perr   [2];
    logic [31:0] tcnt   [2];

    logic [7:0]  mem [2][256];
    int          n_strb [2];
    logic        load_en = 1'b0;
    int          load_d  = 0;
    logic [7:0]  load_a  = '0;
    logic [7:0]  load_v  = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_cpu_bus_tb_stall_bridge #(.STALL_CYCLES(0), .STALL_MASK(8'h07), .MEM_AW(16)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .cpu_address(c_addr[0]), .cpu_read(c_rd[0]), .cpu_write(c_wr[0]),
        .cpu_byteenable(c_be[0]), .cpu_writedata(c_wd[0]),
        .cpu_waitrequest(wreq[0]), .cpu_readdata(rdata[0]),
        .mem_read(m_rd[0]), .mem_write(m_wr[0]), .mem_addr(m_addr[0]),
        .mem_byteenable(m_be[0]), .mem_writedata(m_wd[0]), .mem_readdata(m_rdata[0]),
        .protocol_err(perr[0]), .txn_count(tcnt[0])
    );

    mips_cpu_bus_tb_stall_bridge #(.STALL_CYCLES(3), .STALL_MASK(8'h07), .MEM_AW(16)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .cpu_address(c_addr[1]), .cpu_read(c_rd[1]), .cpu_write(c_wr[1]),
        .cpu_byteenable(c_be[1]), .cpu_writedata(c_wd[1]),
        .cpu_waitrequest(wreq[1]), .cpu_readdata(rdata[1]),
        .mem_read(m_rd[1]), .mem_write(m_wr[1]), .mem_addr(m_addr[1]),
        .mem_byteenable(m_be[1]), .mem_writedata(m_wd[1]), .mem_readdata(m_rdata[1]),
        .protocol_err(perr[1]), .txn_count(tcnt[1])
    );

    function automatic logic [31:0] word_at(input int d, input logic [7:0] a);
        return {mem[d][a + 8'd3], mem[d][a + 8'd2], mem[d][a + 8'd1], mem[d][a]};
    endfunction

    // Bench memories: byte-lane writes, read data registered one cycle later.
    always @(posedge clk) begin
        if (load_en) mem[load_d][load_a] <= load_v;
        for (int d = 0; d < 2; d++) begin
            if (m_wr[d]) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_be[d][i]) mem[d][m_addr[d][7:0] + 8'(i)] <= m_wd[d][8*i +: 8];
                end
            end
            if (m_rd[d]) m_rdata[d] <= word_at(d, m_addr[d][7:0]);
            if (m_rd[d] || m_wr[d]) n_strb[d] <= n_strb[d] + 1;
        end
    end

    task automatic poke(input int d, input logic [7:0] a, input logic [7:0] v);
        @(posedge clk); #1;
        load_en = 1'b1; load_d = d; load_a = a; load_v = v;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            c_addr[d] = '0; c_rd[d] = 1'b0; c_wr[d] = 1'b0; c_be[d] = '0; c_wd[d] = '0;
        end
    endtask

    // One CPU transfer with a bounded wait. done_cyc is the cycle (request
    // cycle = 0) in which waitrequest was low, or -1 on timeout.
    task automatic run_txn(input int d, input bit wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd,
                           input int chg_cyc, input logic [31:0] chg_addr,
                           output int done_cyc, output logic [31:0] rd,
                           output logic [31:0] rd_mask, output logic [31:0] wr_mask);
        done_cyc = -1; rd = '0; rd_mask = '0; wr_mask = '0;
        @(posedge clk); #1;
        c_addr[d] = addr; c_be[d] = be; c_wd[d] = wd; c_rd[d] = !wr; c_wr[d] = wr;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (m_rd[d]) rd_mask[cyc] = 1'b1;
            if (m_wr[d]) wr_mask[cyc] = 1'b1;
            if (!wreq[d]) begin
                done_cyc = cyc;
                rd = rdata[d];
                break;
            end
            @(posedge clk); #1;
            if (cyc + 1 == chg_cyc) c_addr[d] = chg_addr;
        end
        @(posedge clk); #1;
        c_rd[d] = 1'b0; c_wr[d] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (perr[1] !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", perr[1]); end
        checks++; if (tcnt[1] !== 32'd0) begin errors++; $display("FAIL reset_txn: got %0d want 0", tcnt[1]); end
        checks++; if ({m_rd[1], m_wr[1]} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {m_rd[1], m_wr[1]}); end
        checks++; if (m_addr[1] !== 16'h0 || m_be[1] !== 4'h0 || m_wd[1] !== 32'h0) begin
            errors++; $display("FAIL reset_latched: addr %h be %h wd %h want zeros", m_addr[1], m_be[1], m_wd[1]); end
        checks++; if (rdata[1] !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata[1]); end
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        checks++; if (wreq[1] !== 1'b0 || wreq[0] !== 1'b0) begin errors++; $display("FAIL reset_wreq: got %b %b want 0 0", wreq[1], wreq[0]); end
    endtask

    task automatic test_read_stall3();
        int dc; logic [31:0] rd, rm, wm;
        poke(1, 8'd0, 8'h11); poke(1, 8'd1, 8'h22); poke(1, 8'd2, 8'h33); poke(1, 8'd3, 8'h44);
        run_txn(1, 1'b0, 32'h0, 4'hF, 32'h0, -1, 32'h0, dc, rd, rm, wm);
        checks++; if (dc !== 5) begin errors++; $display("FAIL t1_latency: done cycle %0d want 5", dc); end
        checks++; if (rd !== 32'h44332211) begin errors++; $display("FAIL t1_rdata: got %h want 44332211", rd); end
        checks++; if (rm !== 32'h10 || wm !== 32'h0) begin errors++; $display("FAIL t1_strobe: rd %h wr %h want 10 0", rm, wm); end
        @(negedge clk);
        checks++; if (tcnt[1] !== 32'd1) begin errors++; $display("FAIL t1_txn: got %0d want 1", tcnt[1]); end
        checks++; if (rdata[1] !== 32'h44332211) begin errors++; $display("FAIL t1_hold: got %h want 44332211", rdata[1]); end
    endtask

    task automatic test_write_stall0();
        int dc; logic [31:0] rd, rm, wm;
        for (int i = 8; i < 12; i++) poke(0, 8'(i), 8'h00);
        run_txn(0, 1'b1, 32'h8, 4'b0011, 32'hDEADBEEF, -1, 32'h0, dc, rd, rm, wm);
        checks++; if (dc !== 2) begin errors++; $display("FAIL t2_wr_latency: done cycle %0d want 2", dc); end
        checks++; if (wm !== 32'h2 || rm !== 32'h0) begin errors++; $display("FAIL t2_wr_strobe: wr %h rd %h want 2 0", wm, rm); end
        run_txn(0, 1'b0, 32'h8, 4'hF, 32'h0, -1, 32'h0, dc, rd, rm, wm);
        checks++; if (dc !== 2) begin errors++; $display("FAIL t2_rd_latency: done cycle %0d want 2", dc); end
        checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL t2_readback: got %h want 0000beef", rd); end
        checks++; if (tcnt[0] !== 32'd2) begin errors++; $display("FAIL t2_txn: got %0d want 2", tcnt[0]); end
        checks++; if (perr[0] !== 1'b0) begin errors++; $display("FAIL t2_no_err: got %b want 0", perr[0]); end
    endtask

    task automatic test_dual_request();
        int s0; logic [31:0] t0;
        s0 = n_strb[1]; t0 = tcnt[1];
        @(posedge clk); #1;
        c_addr[1] = 32'h0; c_be[1] = 4'hF; c_rd[1] = 1'b1; c_wr[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (wreq[1] !== 1'b1) begin errors++; $display("FAIL t3_wreq_c%0d: got %b want 1", i, wreq[1]); end
        end
        @(posedge clk); #1;
        c_rd[1] = 1'b0; c_wr[1] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (perr[1] !== 1'b1) begin errors++; $display("FAIL t3_perr: got %b want 1", perr[1]); end
        checks++; if (n_strb[1] !== s0) begin errors++; $display("FAIL t3_no_strobe: got %0d want %0d", n_strb[1], s0); end
        checks++; if (tcnt[1] !== t0) begin errors++; $display("FAIL t3_txn: got %0d want %0d", tcnt[1], t0); end
    endtask

    task automatic test_addr_change();
        int dc; logic [31:0] rd, rm, wm;
        poke(1, 8'd4, 8'h55); poke(1, 8'd5, 8'h66); poke(1, 8'd6, 8'h77); poke(1, 8'd7, 8'h88);
        do_reset();
        @(negedge clk);
        checks++; if (perr[1] !== 1'b0) begin errors++; $display("FAIL t4_perr_cleared: got %b want 0", perr[1]); end
        run_txn(1, 1'b0, 32'h0, 4'hF, 32'h0, 1, 32'h4, dc, rd, rm, wm);
        checks++; if (perr[1] !== 1'b1) begin errors++; $display("FAIL t4_perr: got %b want 1", perr[1]); end
        checks++; if (dc !== 5) begin errors++; $display("FAIL t4_latency: done cycle %0d want 5", dc); end
        checks++; if (rd !== 32'h44332211) begin errors++; $display("FAIL t4_rdata: got %h want 44332211", rd); end
        checks++; if (m_addr[1] !== 16'h0) begin errors++; $display("FAIL t4_latched_addr: got %h want 0", m_addr[1]); end
    endtask

    task automatic test_reset_mid_transfer();
        int dc, s0; logic [31:0] rd, rm, wm;
        @(posedge clk); #1;
        c_addr[1] = 32'h4; c_be[1] = 4'hF; c_rd[1] = 1'b1; c_wr[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++; if ({m_rd[1], m_wr[1]} !== 2'b00) begin errors++; $display("FAIL t5_strobes: got %b want 00", {m_rd[1], m_wr[1]}); end
        checks++; if (m_addr[1] !== 16'h0) begin errors++; $display("FAIL t5_addr: got %h want 0", m_addr[1]); end
        checks++; if (tcnt[1] !== 32'd0) begin errors++; $display("FAIL t5_txn: got %0d want 0", tcnt[1]); end
        checks++; if (perr[1] !== 1'b0) begin errors++; $display("FAIL t5_perr: got %b want 0", perr[1]); end
        checks++; if (rdata[1] !== 32'h0) begin errors++; $display("FAIL t5_rdata: got %h want 0", rdata[1]); end
        c_rd[1] = 1'b0;
        s0 = n_strb[1];
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++; if (n_strb[1] !== s0) begin errors++; $display("FAIL t5_no_strobe: got %0d want %0d", n_strb[1], s0); end
        run_txn(1, 1'b0, 32'h4, 4'hF, 32'h0, -1, 32'h0, dc, rd, rm, wm);
        checks++; if (dc !== 5) begin errors++; $display("FAIL t5_latency: done cycle %0d want 5", dc); end
        checks++; if (rd !== 32'h88776655) begin errors++; $display("FAIL t5_rdata_after: got %h want 88776655", rd); end
        checks++; if (tcnt[1] !== 32'd1) begin errors++; $display("FAIL t5_txn_after: got %0d want 1", tcnt[1]); end
    endtask

`ifdef STALL_RANDOM_EN
    task automatic test_random_stall();
        int dc, nd; logic [31:0] rd, rm, wm, exp; logic [7:0] a; logic [7:0] seen;
        seen = '0;
        for (int i = 0; i < 256; i++) poke(1, 8'(i), 8'(i * 7 + 3));
        for (int n = 0; n < 64; n++) begin
            a = {6'($urandom_range(0, 63)), 2'b00};
            exp = {8'((a + 3) * 7 + 3), 8'((a + 2) * 7 + 3), 8'((a + 1) * 7 + 3), 8'(a * 7 + 3)};
            run_txn(1, 1'b0, {24'h0, a}, 4'hF, 32'h0, -1, 32'h0, dc, rd, rm, wm);
            checks++; if (dc < 2 || dc > 9) begin errors++; $display("FAIL t6_stall_n%0d: done cycle %0d want 2..9", n, dc); end
            else seen[dc - 2] = 1'b1;
            checks++; if (rd !== exp) begin errors++; $display("FAIL t6_data_n%0d: got %h want %h", n, rd, exp); end
        end
        nd = 0;
        for (int i = 0; i < 8; i++) if (seen[i]) nd++;
        checks++; if (nd < 4) begin errors++; $display("FAIL t6_distinct: got %0d want >=4", nd); end
    endtask
`endif

    initial begin
        n_strb[0] = 0; n_strb[1] = 0;
        m_rdata[0] = '0; m_rdata[1] = '0;
        test_reset();
`ifdef STALL_RANDOM_EN
        test_dual_request();
        do_reset();
        test_random_stall();
`else
        test_read_stall3();
        test_write_stall0();
        test_dual_request();
        test_addr_change();
        test_reset_mid_transfer();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1);
    end

endmodule
